change_dispenser: RTL and testbench

//  Return side of the vending coin interface: drives coins back out using the 2-bit coin code the machine accepts
//  (2'b01 = 1 unit, 2'b10 = 2 units). Takes a change request, dispenses greedily (2-unit first) through a

---
 rtl/vend_pkg.sv | 27 ++
 rtl/coin_inventory.sv | 41 ++++
 rtl/change_dispenser.sv | 137 +++++++++++++
 tb/tb_change_dispenser.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Coin codes, FSM state encoding and coin helpers shared by the vending
// machine's coin-accepting and change-returning FSMs.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_ONE  = 2'b01;
    localparam logic [1:0] COIN_TWO  = 2'b10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SELECT = 3'd1;
    localparam state_t ST_FIRE   = 3'd2;
    localparam state_t ST_GAP    = 3'd3;
    localparam state_t ST_DONE   = 3'd4;
    localparam state_t ST_FAULT  = 3'd5;

    // Face value in units of a coin code; unknown codes are worth nothing.
    function automatic logic [1:0] coin_val(input logic [1:0] code);
        case (code)
            COIN_ONE: coin_val = 2'd1;
            COIN_TWO: coin_val = 2'd2;
            default:  coin_val = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin stock: two saturating up/down counters driven by
// refill (coin loaded) and take (coin dispensed) strobes.
module coin_inventory #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             refill_one,
    input  logic             refill_two,
    input  logic             take_one,
    input  logic             take_two,
    output logic [CNT_W-1:0] inv_one,
    output logic [CNT_W-1:0] inv_two
);

    // A simultaneous refill and take cancel out, even when the counter is full.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cnt,
        input logic             up,
        input logic             down
    );
        next_count = cnt;
        if (up && !down && cnt != '1)
            next_count = cnt + 1'b1;
        else if (down && !up && cnt != '0)
            next_count = cnt - 1'b1;
    endfunction

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values; blocking here would create ordering-dependent logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_one <= '0;
            inv_two <= '0;
        end else begin
            inv_one <= next_count(inv_one, refill_one, take_one);
            inv_two <= next_count(inv_two, refill_two, take_two);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change return FSM: pays a requested amount greedily (2-unit coins first)
// through a fire/ack hopper handshake and reports timeout or lack of coins.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W   = 4,
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 64,
    parameter int GAP_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic [1:0]       coin_out,
    output logic             coin_fire,
    input  logic             coin_ack,
    output logic             done,
    output logic             fault,
    input  logic             fault_clr,
    output logic [AMT_W-1:0] shortfall,
    output logic [AMT_W-1:0] paid_out,
    input  logic             refill_one,
    input  logic             refill_two,
    output logic [CNT_W-1:0] inv_one,
    output logic [CNT_W-1:0] inv_two
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    state_t           state;
    logic [1:0]       code;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] paid;
    logic [TMR_W-1:0] timer;
    logic [GAP_W-1:0] gap_cnt;

    logic             ack_take;
    logic             take_one;
    logic             take_two;
    logic [AMT_W-1:0] code_units;

    assign ack_take   = (state == ST_FIRE) && coin_ack;
    assign take_one   = ack_take && (code == COIN_ONE);
    assign take_two   = ack_take && (code == COIN_TWO);
    assign code_units = AMT_W'(coin_val(code));

    coin_inventory #(
        .CNT_W (CNT_W)
    ) u_inventory (
        .clk        (clk),
        .rst        (rst),
        .refill_one (refill_one),
        .refill_two (refill_two),
        .take_one   (take_one),
        .take_two   (take_two),
        .inv_one    (inv_one),
        .inv_two    (inv_two)
    );

    // NOTE: every datapath register is reset so an aborted transaction leaves
    // no stale remainder or coin code behind for the next request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            code    <= COIN_NONE;
            rem     <= '0;
            paid    <= '0;
            timer   <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        rem   <= req_amount;
                        paid  <= '0;
                        state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    timer <= '0;
                    // Greedy pick; the rem guards keep rem from underflowing.
                    if (rem == '0) begin
                        state <= ST_DONE;
                    end else if (rem >= AMT_W'(2) && inv_two != '0) begin
                        code  <= COIN_TWO;
                        state <= ST_FIRE;
                    end else if (inv_one != '0) begin
                        code  <= COIN_ONE;
                        state <= ST_FIRE;
                    end else begin
                        state <= ST_FAULT;
                    end
                end
                ST_FIRE: begin
                    if (coin_ack) begin
                        rem     <= rem - code_units;
                        paid    <= paid + code_units;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        state <= ST_FAULT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1))
                        state <= ST_SELECT;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_FAULT: begin
                    if (fault_clr)
                        state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign coin_fire = (state == ST_FIRE);
    assign coin_out  = (state == ST_FIRE) ? code : COIN_NONE;
    assign done      = (state == ST_DONE);
    assign fault     = (state == ST_FAULT);
    assign shortfall = (state == ST_FAULT) ? rem : '0;
    assign paid_out  = paid;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized
// requests checked against a greedy coin-by-coin reference model.
module tb_change_dispenser;

    localparam int AMT_W   = 4;
    localparam int CNT_W   = 6;
    localparam int TIMEOUT = 64;
    localparam int GAP_CYC = 2;
    localparam int INV_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic [1:0]       coin_out;
    logic             coin_fire;
    logic             coin_ack;
    logic             done;
    logic             fault;
    logic             fault_clr;
    logic [AMT_W-1:0] shortfall;
    logic [AMT_W-1:0] paid_out;
    logic             refill_one;
    logic             refill_two;
    logic [CNT_W-1:0] inv_one;
    logic [CNT_W-1:0] inv_two;

    int total = 0;
    int bad   = 0;
    int m_one = 0;
    int m_two = 0;

    always #5 clk = ~clk;

    change_dispenser #(
        .AMT_W   (AMT_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_amount (req_amount),
        .req_ready  (req_ready),
        .coin_out   (coin_out),
        .coin_fire  (coin_fire),
        .coin_ack   (coin_ack),
        .done       (done),
        .fault      (fault),
        .fault_clr  (fault_clr),
        .shortfall  (shortfall),
        .paid_out   (paid_out),
        .refill_one (refill_one),
        .refill_two (refill_two),
        .inv_one    (inv_one),
        .inv_two    (inv_two)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    function automatic int bump(input int cnt, input bit up, input bit down);
        if (up && down) return cnt;
        if (up)         return (cnt < INV_MAX) ? cnt + 1 : cnt;
        if (down)       return (cnt > 0) ? cnt - 1 : cnt;
        return cnt;
    endfunction

    task automatic reset_dut();
        rst = 1'b1; req_valid = 1'b0; req_amount = '0; coin_ack = 1'b0;
        fault_clr = 1'b0; refill_one = 1'b0; refill_two = 1'b0;
        step();
        step();
        rst = 1'b0;
        m_one = 0;
        m_two = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready, 1);
        check({tag, "_coin_out"}, coin_out, 0);
        check({tag, "_fire"}, coin_fire, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_shortfall"}, shortfall, 0);
        check({tag, "_paid"}, paid_out, 0);
        check({tag, "_inv_one"}, inv_one, 0);
        check({tag, "_inv_two"}, inv_two, 0);
    endtask

    task automatic do_refill(input int n1, input int n2);
        int n;
        n = (n1 > n2) ? n1 : n2;
        for (int i = 0; i < n; i++) begin
            refill_one = (i < n1);
            refill_two = (i < n2);
            step();
            m_one = bump(m_one, i < n1, 1'b0);
            m_two = bump(m_two, i < n2, 1'b0);
        end
        refill_one = 1'b0;
        refill_two = 1'b0;
        check("refill_inv_one", inv_one, m_one);
        check("refill_inv_two", inv_two, m_two);
    endtask

    // One whole request: each coin is predicted greedily from the model stock,
    // and the expected ack-to-next-fire spacing is GAP_CYC+2 edges.
    task automatic run_request(input int amt, input int fixed_d, input bit rnd, input bit refill_on_ack);
        int rem, paid, val, d;
        bit finished;
        rem = amt; paid = 0; finished = 1'b0;
        check("idle_ready", req_ready, 1);
        req_valid = 1'b1; req_amount = AMT_W'(amt);
        step();
        req_valid = 1'b0;
        check("busy_ready", req_ready, 0);
        check("select_no_fire", coin_fire, 0);
        for (int n = 0; n < 20; n++) begin
            step();
            if (rem == 0) begin
                check("done_pulse", done, 1);
                check("done_shortfall", shortfall, 0);
                check("done_paid", paid_out, paid);
                step();
                check("done_drop", done, 0);
                check("done_ready", req_ready, 1);
                finished = 1'b1;
                break;
            end
            val = (rem >= 2 && m_two > 0) ? 2 : (m_one > 0) ? 1 : 0;
            if (val == 0) begin
                check("fault_flag", fault, 1);
                check("fault_shortfall", shortfall, rem);
                check("fault_paid", paid_out, paid);
                check("fault_no_fire", coin_fire, 0);
                check("fault_no_done", done, 0);
                fault_clr = 1'b1;
                step();
                fault_clr = 1'b0;
                check("fault_cleared", fault, 0);
                check("fault_ready", req_ready, 1);
                finished = 1'b1;
                break;
            end
            check("fire_rise", coin_fire, 1);
            check("fire_code", coin_out, val);
            d = rnd ? int'($urandom_range(0, 6)) : fixed_d;
            repeat (d) step();
            check("fire_held", coin_fire, 1);
            coin_ack = 1'b1;
            refill_two = refill_on_ack;
            step();
            coin_ack = 1'b0;
            refill_two = 1'b0;
            m_two = bump(m_two, refill_on_ack, val == 2);
            m_one = bump(m_one, 1'b0, val == 1);
            rem -= val;
            paid += val;
            check("gap_no_fire", coin_fire, 0);
            check("gap_coin_out", coin_out, 0);
            check("gap_paid", paid_out, paid);
            check("gap_inv_one", inv_one, m_one);
            check("gap_inv_two", inv_two, m_two);
            step();
            check("gap2_no_fire", coin_fire, 0);
            step();
        end
        if (!finished)
            check("request_finished", finished, 1);
    endtask

    initial begin
        reset_dut();
        check_reset_outputs("reset");

        // Mixed denominations, greedy 10,10,01.
        do_refill(3, 3);
        run_request(5, 3, 1'b0, 1'b0);
        check("t1_paid", paid_out, 5);
        check("t1_inv_two", inv_two, 1);
        check("t1_inv_one", inv_one, 2);

        // Only 1-unit coins available.
        reset_dut();
        do_refill(4, 0);
        run_request(3, 1, 1'b0, 1'b0);
        check("t2_inv_one", inv_one, 1);

        // Runs out of change after one 2-unit coin.
        reset_dut();
        do_refill(0, 1);
        run_request(3, 2, 1'b0, 1'b0);
        check("t3_paid", paid_out, 2);

        // Hopper timeout, then ack on the final allowed cycle.
        reset_dut();
        do_refill(0, 1);
        req_valid = 1'b1; req_amount = AMT_W'(2);
        step();
        req_valid = 1'b0;
        step();
        check("to_fire", coin_fire, 1);
        repeat (TIMEOUT - 1) step();
        check("to_not_yet", fault, 0);
        check("to_still_firing", coin_fire, 1);
        step();
        check("to_fault", fault, 1);
        check("to_fire_off", coin_fire, 0);
        check("to_shortfall", shortfall, 2);
        check("to_inv_two", inv_two, 1);
        check("to_paid", paid_out, 0);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("to_cleared", req_ready, 1);

        req_valid = 1'b1; req_amount = AMT_W'(2);
        step();
        req_valid = 1'b0;
        step();
        repeat (TIMEOUT - 1) step();
        coin_ack = 1'b1;
        step();
        coin_ack = 1'b0;
        m_two = 0;
        check("late_ack_no_fault", fault, 0);
        check("late_ack_inv_two", inv_two, 0);
        check("late_ack_paid", paid_out, 2);
        repeat (3) step();
        check("late_ack_done", done, 1);

        // Refill cancels a dispense; refill saturation.
        reset_dut();
        do_refill(0, 2);
        run_request(2, 1, 1'b0, 1'b1);
        check("t5_inv_two", inv_two, 2);
        do_refill(INV_MAX + 6, 0);
        check("t5_sat", inv_one, INV_MAX);

        // Reset during FIRE, then a zero-amount request.
        reset_dut();
        do_refill(1, 1);
        req_valid = 1'b1; req_amount = AMT_W'(3);
        step();
        req_valid = 1'b0;
        step();
        check("t6_firing", coin_fire, 1);
        rst = 1'b1;
        step();
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        m_one = 0;
        m_two = 0;
        run_request(0, 0, 1'b0, 1'b0);

        // Randomized traffic against the model.
        reset_dut();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_refill(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            run_request(int'($urandom_range(0, 9)), 0, 1'b1, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
